imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Extracts and extends the RISC-V immediate of one instruction per cycle for XLEN 32 or 64, adds the CSR zimm format and an immediate-type tag, and carries a sideband tag. The result is registered behind a valid/ready interface with a two-entry skid buffer, so the block sits between fetch and the register-read stage without a combinational ready path.

---
 rtl/imm_gen_pkg.sv | 22 ++
 rtl/imm_gen_pipe_if.sv | 23 ++
 rtl/imm_decode.sv | 45 ++++
 rtl/imm_gen_pipe.sv | 63 ++++++
 tb/tb_imm_gen_pipe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate types, opcodes and skid-buffer states for imm_gen_pipe
package imm_gen_pkg;
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_Z
  } imm_type_e;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream/downstream handshake and payload of imm_gen_pipe
interface imm_gen_pipe_if #(parameter int XLEN = 32, parameter int TAG_W = 8);
  import imm_gen_pkg::*;
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instr;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_imm;
  imm_type_e        o_imm_type;
  logic             o_illegal;
  logic [TAG_W-1:0] o_tag;
  modport slave (
    input  i_flush, i_valid, i_instr, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_imm_type, o_illegal, o_tag
  );
  modport master (
    output i_flush, i_valid, i_instr, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_imm_type, o_illegal, o_tag
  );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational RISC-V immediate extraction and extension to XLEN
module imm_decode import imm_gen_pkg::*; #(parameter int XLEN = 32) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            illegal
);
  logic [31:0] raw;
  always_comb begin
    raw = '0;
    imm_type = IMM_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        raw = {{20{instr[31]}}, instr[31:20]};
        imm_type = IMM_I;
      end
      OP_STORE: begin
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_type = IMM_S;
      end
      OP_BRANCH: begin
        raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        raw = {instr[31:12], 12'b0};
        imm_type = IMM_U;
      end
      OP_JAL: begin
        raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OP_SYSTEM: begin
        // funct3 >= 4 selects the CSR immediate forms (zimm in rs1)
        if (instr[14:12] >= 3'd4) begin
          raw = {27'b0, instr[19:15]};
          imm_type = IMM_Z;
        end
      end
      default: illegal = 1'b1;
    endcase
  end
  assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a two-entry skid buffer
module imm_gen_pipe import imm_gen_pkg::*; #(parameter int XLEN = 32, parameter int TAG_W = 8) (
  input logic          i_clk,
  input logic          i_rst_n,
  imm_gen_pipe_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        ty;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } pay_t;
  state_e state, state_nx;
  pay_t d_pay, main_q, skid_q;
  logic in_x, out_x, load_main, load_skid, from_skid;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr    (bus.i_instr),
    .imm      (d_pay.imm),
    .imm_type (d_pay.ty),
    .illegal  (d_pay.ill)
  );
  assign d_pay.tag = bus.i_tag;
  assign in_x = bus.i_valid && bus.o_ready;
  assign out_x = bus.o_valid && bus.i_ready;
  always_comb begin
    state_nx = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (bus.i_flush) state_nx = S_EMPTY;
    else case (state)
      S_EMPTY: if (in_x) begin
        state_nx = S_ONE;
        load_main = 1'b1;
      end
      S_ONE: if (in_x && !out_x) begin
        state_nx = S_FULL;
        load_skid = 1'b1;
      end else if (in_x) load_main = 1'b1;
      else if (out_x) state_nx = S_EMPTY;
      S_FULL: if (out_x) begin
        state_nx = S_ONE;
        load_main = 1'b1;
        from_skid = 1'b1;
      end
      default: state_nx = S_EMPTY;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= S_EMPTY;
    else state <= state_nx;
  // payload is qualified by state, so it carries no reset
  always_ff @(posedge i_clk) begin
    if (load_main) main_q <= from_skid ? skid_q : d_pay;
    if (load_skid) skid_q <= d_pay;
  end
  assign bus.o_valid = state != S_EMPTY;
  assign bus.o_ready = state != S_FULL;
  assign bus.o_imm = main_q.imm;
  assign bus.o_imm_type = main_q.ty;
  assign bus.o_illegal = main_q.ill;
  assign bus.o_tag = main_q.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
    logic [7:0]  tag;
  } ent_t;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  ent_t q[$];
  int checks = 0;
  int failures = 0;
  always #5 i_clk = ~i_clk;
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();
  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b64));
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask
  function automatic ent_t mk(input logic [63:0] imm, input logic [2:0] ty, input logic ill);
    ent_t e;
    e.imm = imm; e.ty = ty; e.ill = ill; e.tag = 8'h00;
    return e;
  endfunction
  function automatic ent_t model(input logic [31:0] ins);
    ent_t m;
    logic [6:0] op;
    op = ins[6:0];
    m = mk(64'h0, 3'd0, 1'b0);
    if (op inside {7'h13, 7'h03, 7'h67}) begin
      m.imm = 64'($signed(ins[31:20])); m.ty = 3'd1;
    end else if (op == 7'h23) begin
      m.imm = 64'($signed({ins[31:25], ins[11:7]})); m.ty = 3'd2;
    end else if (op == 7'h63) begin
      m.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); m.ty = 3'd3;
    end else if (op == 7'h37 || op == 7'h17) begin
      m.imm = 64'($signed({ins[31:12], 12'h000})); m.ty = 3'd4;
    end else if (op == 7'h6f) begin
      m.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); m.ty = 3'd5;
    end else if (op == 7'h73) begin
      if (ins[14]) begin m.imm = {59'b0, ins[19:15]}; m.ty = 3'd6; end
    end else m.ill = 1'b1;
    return m;
  endfunction
  function automatic logic [31:0] rnd();
    logic [6:0] ops [11];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73, 7'h33, 7'h0b};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 10)]};
  endfunction
  task automatic set_in(input logic v, input logic [31:0] ins, input logic [7:0] tag, input logic rdy, input logic fl);
    b32.i_valid = v; b32.i_instr = ins; b32.i_tag = tag; b32.i_ready = rdy; b32.i_flush = fl;
    b64.i_valid = v; b64.i_instr = ins; b64.i_tag = tag; b64.i_ready = rdy; b64.i_flush = fl;
  endtask
  // called at a falling edge; samples, scores, then advances one full cycle
  task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] tag, input logic rdy, input logic fl, input ent_t e);
    ent_t h;
    logic inx, outx;
    set_in(v, ins, tag, rdy, fl);
    #1;
    chk("valid32", b32.o_valid, q.size() > 0);
    chk("valid64", b64.o_valid, q.size() > 0);
    chk("ready32", b32.o_ready, q.size() < 2);
    chk("ready64", b64.o_ready, q.size() < 2);
    inx = v && (q.size() < 2);
    outx = rdy && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (outx) begin
        h = q.pop_front();
        chk("imm32", b32.o_imm, h.imm[31:0]);
        chk("imm64", b64.o_imm, h.imm);
        chk("type32", b32.o_imm_type, h.ty);
        chk("type64", b64.o_imm_type, h.ty);
        chk("ill32", b32.o_illegal, h.ill);
        chk("ill64", b64.o_illegal, h.ill);
        chk("tag32", b32.o_tag, h.tag);
        chk("tag64", b64.o_tag, h.tag);
      end
      if (inx) begin
        e.tag = tag;
        q.push_back(e);
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask
  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 8'h00, rdy, 1'b0, model(32'h0));
  endtask
  task automatic send(input logic [31:0] ins, input logic [7:0] tag, input logic rdy);
    drive(1'b1, ins, tag, rdy, 1'b0, model(ins));
  endtask
  initial begin
    logic [31:0] a, b, c;
    set_in(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    #2;
    chk("rst_valid32", b32.o_valid, 1'b0);
    chk("rst_valid64", b64.o_valid, 1'b0);
    chk("rst_ready32", b32.o_ready, 1'b1);
    chk("rst_ready64", b64.o_ready, 1'b1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1'b1, 32'hFFF00093, 8'd1, 1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 1'b0));
    drive(1'b1, 32'hFE000EE3, 8'd2, 1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFC, IMM_B, 1'b0));
    drive(1'b1, 32'h0010006F, 8'd3, 1'b1, 1'b0, mk(64'h0000_0000_0000_0800, IMM_J, 1'b0));
    drive(1'b1, 32'h800000B7, 8'd4, 1'b1, 1'b0, mk(64'hFFFF_FFFF_8000_0000, IMM_U, 1'b0));
    drive(1'b1, 32'h300FD073, 8'd5, 1'b1, 1'b0, mk(64'h0000_0000_0000_001F, IMM_Z, 1'b0));
    drive(1'b1, 32'h0000000B, 8'd6, 1'b1, 1'b0, mk(64'h0, IMM_NONE, 1'b1));
    drive(1'b1, 32'h00000073, 8'd7, 1'b1, 1'b0, mk(64'h0, IMM_NONE, 1'b0));
    drive(1'b1, 32'hFE112E23, 8'd8, 1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFC, IMM_S, 1'b0));
    idle(1'b1);
    idle(1'b1);
    a = rnd(); b = rnd(); c = rnd();
    send(a, 8'd1, 1'b0);
    send(b, 8'd2, 1'b0);
    send(c, 8'd3, 1'b0);
    send(c, 8'd3, 1'b1);
    send(c, 8'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 16; i++) send(rnd(), 8'(8'h80 + i), 1'b1);
    idle(1'b1);
    idle(1'b1);
    send(rnd(), 8'h11, 1'b0);
    send(rnd(), 8'h12, 1'b0);
    drive(1'b1, 32'hFFF00093, 8'h99, 1'b0, 1'b1, model(32'hFFF00093));
    idle(1'b1);
    send(rnd(), 8'h21, 1'b0);
    drive(1'b1, 32'hFFF00093, 8'h22, 1'b0, 1'b1, model(32'hFFF00093));
    idle(1'b1);
    idle(1'b1);
    send(rnd(), 8'h31, 1'b0);
    send(rnd(), 8'h32, 1'b0);
    set_in(1'b1, 32'h800000B7, 8'h33, 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid32", b32.o_valid, 1'b0);
    chk("arst_valid64", b64.o_valid, 1'b0);
    chk("arst_ready32", b32.o_ready, 1'b1);
    chk("arst_ready64", b64.o_ready, 1'b1);
    q.delete();
    @(negedge i_clk);
    set_in(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    send(32'h0010006F, 8'h40, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("sb_drained", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
